// File: rtl/noc_leaf_injector.sv
// Leaf network interface: packs PE writes into {src, dest, data}, buffers them in a small FIFO and
// drives each packet into the router over a 4-phase req/ack link. Option: INJ_SENT_CNT_EN.
module noc_leaf_injector #(
  parameter int unsigned            WIDTH_packet = 14,
  parameter int unsigned            WIDTH_addr   = 3,
  parameter int unsigned            WIDTH_dest   = 3,
  parameter int unsigned            WIDTH_data   = 8,
  parameter logic [WIDTH_addr-1:0]  ADDR         = 3'b000,
  parameter int unsigned            DEPTH        = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pe_valid,
  output logic                      pe_ready,
  input  logic [WIDTH_dest-1:0]     pe_dest,
  input  logic [WIDTH_data-1:0]     pe_data,
  output logic                      net_req,
  input  logic                      net_ack,
  output logic [WIDTH_packet-1:0]   net_data,
  output logic [$clog2(DEPTH):0]    fifo_count
`ifdef INJ_SENT_CNT_EN
  ,
  output logic [15:0]               sent_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [WIDTH_packet-1:0] mem_q [DEPTH];
  logic [AW:0]             wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count;
  logic                    full, empty, push, pop;

  logic                    ack_meta_q, ack_s_q;
  logic [1:0]              state_q, state_d;
  logic                    net_req_q, net_req_d;
  logic [WIDTH_packet-1:0] net_data_q, net_data_d;

  // Extra pointer bit makes the subtraction a direct occupancy count.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign full       = (count == FullCnt);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign pe_ready   = !full;
  assign push       = pe_valid && pe_ready;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {ADDR, pe_dest, pe_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // net_ack is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= net_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // The head is popped at load, so net_data lives in its own register and req follows a cycle later.
  always_comb begin
    state_d    = state_q;
    net_req_d  = net_req_q;
    net_data_d = net_data_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop        = 1'b1;
          net_data_d = mem_q[rd_ptr_q[AW-1:0]];
          state_d    = StReq;
        end
      end
      StReq: begin
        if (ack_s_q) begin
          net_req_d = 1'b0;
          state_d   = StRelease;
        end else begin
          net_req_d = 1'b1;
        end
      end
      StRelease: begin
        if (!ack_s_q) state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        net_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      net_req_q  <= 1'b0;
      net_data_q <= '0;
    end else begin
      state_q    <= state_d;
      net_req_q  <= net_req_d;
      net_data_q <= net_data_d;
    end
  end

  assign net_req  = net_req_q;
  assign net_data = net_data_q;

`ifdef INJ_SENT_CNT_EN
  logic        sent_inc;
  logic [15:0] sent_cnt_q, sent_cnt_d;

  assign sent_inc   = (state_q == StReq) && ack_s_q;
  assign sent_cnt_d = sent_cnt_q + {15'd0, sent_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sent_cnt_q <= '0;
    else        sent_cnt_q <= sent_cnt_d;
  end

  assign sent_cnt = sent_cnt_q;
`endif

endmodule
